// File: rtl/bg_vram_responder_pkg.sv
// Shared constants, slot state and tag types for the background VRAM responder.
// Source index is layer*4+kind; layer 0 char is source 0.
package bg_vram_pkg;

    localparam int NUM_LAYERS = 4;
    localparam int NUM_KINDS  = 4;
    localparam int NUM_SRC    = NUM_LAYERS * NUM_KINDS;
    localparam int SRC_W      = 4;

    localparam logic [1:0] KIND_CHAR = 2'd0;
    localparam logic [1:0] KIND_PAL  = 2'd1;
    localparam logic [1:0] KIND_TLO  = 2'd2;
    localparam logic [1:0] KIND_THI  = 2'd3;

    typedef logic [SRC_W-1:0] src_t;

    typedef enum logic [1:0] {
        SRC_IDLE   = 2'd0,
        SRC_PEND   = 2'd1,
        SRC_FLIGHT = 2'd2
    } srcState_t;

    typedef struct packed {
        logic valid;
        src_t src;
    } tag_t;

    function automatic src_t src_idx(input logic [1:0] layer, input logic [1:0] kind);
        return {layer, kind};
    endfunction

endpackage

// File: rtl/bg_vram_responder_if.sv
// Source-side and VRAM-side signal bundle of the background VRAM responder.
// slave = responder view, master = layer controllers plus VRAM view.
interface bg_vram_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    import bg_vram_pkg::*;

    logic [NUM_SRC-1:0]        req_valid;
    logic [NUM_SRC*ADDR_W-1:0] req_addr;
    logic [NUM_SRC-1:0]        req_ready;
    logic [NUM_SRC-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      mem_req;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      mem_gnt;
    logic [DATA_W-1:0]         mem_rdata;

    modport slave (
        input  req_valid, req_addr, mem_gnt, mem_rdata,
        output req_ready, rsp_valid, rsp_data, mem_req, mem_addr
    );

    modport master (
        output req_valid, req_addr, mem_gnt, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, mem_req, mem_addr
    );

endinterface

// File: rtl/bg_vram_responder_arb.sv
// 16-way arbiter: first requester found scanning upward from ptr (wrapping).
// A constant ptr of zero turns it into lowest-index-wins fixed priority.
module bg_vram_rr_arb
    import bg_vram_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  src_t               ptr,
    output logic [NUM_SRC-1:0] gnt,
    output src_t               idx,
    output logic               any
);

    src_t cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand = ptr + src_t'(i);
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bg_vram_responder.sv
// Arbitrates 16 background fetch sources onto one VRAM read port and routes data back.
// Define BG_VRAM_FIXED_PRIO_EN for fixed priority (lowest source wins) instead of round-robin.
module bg_vram_responder
    import bg_vram_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 2
)
(
    input logic               clk,
    input logic               reset,
    bg_vram_responder_if.slave bus
);

    srcState_t          state    [NUM_SRC];
    srcState_t          stateNxt [NUM_SRC];
    logic [ADDR_W-1:0]  slotAddr [NUM_SRC];
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] win;
    src_t               winIdx;
    src_t               ptr;
    logic               anyPend;
    logic               issue;
    tag_t               tagPipe  [MEM_LAT+1];

    always_comb begin
        pend          = '0;
        bus.req_ready = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            pend[s]          = (state[s] == SRC_PEND);
            bus.req_ready[s] = (state[s] == SRC_IDLE);
        end
    end

    bg_vram_rr_arb arb (
        .req (pend),
        .ptr (ptr),
        .gnt (win),
        .idx (winIdx),
        .any (anyPend)
    );

    assign issue        = anyPend & bus.mem_gnt;
    assign bus.mem_req  = anyPend;
    assign bus.mem_addr = anyPend ? slotAddr[winIdx] : '0;

    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            stateNxt[s] = state[s];
            unique case (state[s])
                SRC_IDLE:   if (bus.req_valid[s]) stateNxt[s] = SRC_PEND;
                SRC_PEND:   if (issue && win[s]) stateNxt[s] = SRC_FLIGHT;
                SRC_FLIGHT: if (bus.rsp_valid[s]) stateNxt[s] = SRC_IDLE;
                default:    stateNxt[s] = SRC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                state[s]    <= SRC_IDLE;
                slotAddr[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                state[s] <= stateNxt[s];
                if (bus.req_valid[s] && state[s] == SRC_IDLE)
                    slotAddr[s] <= bus.req_addr[s*ADDR_W +: ADDR_W];
            end
        end
    end

`ifdef BG_VRAM_FIXED_PRIO_EN
    assign ptr = '0;
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= '0;
        else if (issue)
            ptr <= winIdx + src_t'(1);
    end
`endif

    // mem_rdata for a grant arrives MEM_LAT edges after the grant edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= MEM_LAT; i++)
                tagPipe[i] <= '0;
        end else begin
            tagPipe[0] <= '{valid: issue, src: winIdx};
            for (int i = 1; i <= MEM_LAT; i++)
                tagPipe[i] <= tagPipe[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
        end else begin
            bus.rsp_valid <= '0;
            if (tagPipe[MEM_LAT].valid) begin
                bus.rsp_valid[tagPipe[MEM_LAT].src] <= 1'b1;
                bus.rsp_data                        <= bus.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_bg_vram_responder.sv
// Self-checking bench for bg_vram_responder: directed scenarios plus random traffic
// against a per-source countdown reference model and a latency-MEM_LAT VRAM model.
module tb_bg_vram_responder;
    import bg_vram_pkg::*;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 8;
    localparam int MEM_LAT = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;

    bg_vram_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    bg_vram_responder #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] memData(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endfunction

    // VRAM: data for a granted address appears MEM_LAT edges after the grant edge
    logic [DATA_W-1:0] mPipe [MEM_LAT+1];
    always @(posedge clk) begin
        mPipe[0] <= (bus.mem_req && bus.mem_gnt) ? memData(bus.mem_addr) : DATA_W'($urandom);
        for (int i = 1; i <= MEM_LAT; i++)
            mPipe[i] <= mPipe[i-1];
    end
    assign bus.mem_rdata = mPipe[MEM_LAT];

    int nChk = 0;
    int nPass = 0;
    int nFail = 0;

    logic [15:0] tbAddr [16];
    int          mSt    [16];
    int          mCnt   [16];
    logic [15:0] mAddr  [16];
    int          mPtr;
    logic [15:0] eRspValid;
    logic [7:0]  eRspData;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nChk++;
        assert (got === exp) nPass++;
        else begin
            nFail++;
            $error("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic int modelWinner();
        int start;
        int s;
`ifdef BG_VRAM_FIXED_PRIO_EN
        start = 0;
`else
        start = mPtr;
`endif
        for (int i = 0; i < 16; i++) begin
            s = (start + i) % 16;
            if (mSt[s] == 1) return s;
        end
        return -1;
    endfunction

    task automatic modelReset();
        for (int s = 0; s < 16; s++) begin
            mSt[s]   = 0;
            mCnt[s]  = 0;
            mAddr[s] = '0;
        end
        mPtr      = 0;
        eRspValid = '0;
        eRspData  = '0;
    endtask

    task automatic modelAdvance(input logic [15:0] v, input logic g);
        int w;
        int oldSt [16];
        w = modelWinner();
        eRspValid = '0;
        for (int s = 0; s < 16; s++) oldSt[s] = mSt[s];
        for (int s = 0; s < 16; s++) begin
            case (oldSt[s])
                0: if (v[s]) begin
                    mSt[s]   = 1;
                    mAddr[s] = tbAddr[s];
                end
                1: if (g && w == s) begin
                    mSt[s]  = 2;
                    mCnt[s] = MEM_LAT + 1;
                end
                2: if (mCnt[s] == 0) mSt[s] = 0;
                   else begin
                       mCnt[s]--;
                       if (mCnt[s] == 0) begin
                           eRspValid[s] = 1'b1;
                           eRspData     = memData(mAddr[s]);
                       end
                   end
                default: mSt[s] = 0;
            endcase
        end
        if (g && w >= 0) mPtr = (w + 1) % 16;
    endtask

    task automatic checkAll();
        int w;
        logic [15:0] eReady;
        w = modelWinner();
        for (int s = 0; s < 16; s++) eReady[s] = (mSt[s] == 0);
        chk("req_ready", 32'(bus.req_ready), 32'(eReady));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(eRspValid));
        chk("rsp_data", 32'(bus.rsp_data), 32'(eRspData));
        chk("mem_req", 32'(bus.mem_req), 32'(w >= 0));
        chk("mem_addr", 32'(bus.mem_addr), (w >= 0) ? 32'(mAddr[w]) : 32'h0);
    endtask

    task automatic step(input logic [15:0] v, input logic g);
        @(negedge clk);
        checkAll();
        bus.req_valid = v;
        bus.mem_gnt   = g;
        for (int s = 0; s < 16; s++) bus.req_addr[s*ADDR_W +: ADDR_W] = tbAddr[s];
        modelAdvance(v, g);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.mem_gnt   = 1'b0;
        modelReset();
        #1;
        checkAll();
        @(negedge clk);
        reset = 1'b0;
    endtask

    int lat;
    int cnt;
    logic [15:0] bit15, bit3;

    initial begin
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.mem_gnt   = 1'b0;
        for (int s = 0; s < 16; s++) tbAddr[s] = '0;
        modelReset();

        // 1: single request from layer 1 pal, exact latency
        doReset();
        tbAddr[src_idx(2'd1, KIND_PAL)] = 16'h1234;
        step(16'h0020, 1'b1);
        lat = -1;
        for (int k = 0; k < 10; k++) begin
            step(16'h0000, 1'b1);
            if (k == 0) chk("t1_mem_addr", 32'(bus.mem_addr), 32'h1234);
            if (bus.rsp_valid == 16'h0020 && lat < 0) lat = k;
        end
        chk("t1_latency", 32'(lat), 32'(MEM_LAT + 2));

        // 2: all sources at once drain in order with one response each
        doReset();
        for (int s = 0; s < 16; s++) tbAddr[s] = 16'($urandom);
        step(16'hFFFF, 1'b1);
        cnt = 0;
        for (int k = 0; k < 24; k++) begin
            step(16'h0000, 1'b1);
            if (bus.rsp_valid != 0) cnt++;
        end
        chk("t2_rsp_count", 32'(cnt), 32'd16);

        // 3: pointer at 14, then sources 3 and 15 pending together
        doReset();
        tbAddr[13] = 16'hD00D;
        step(16'h2000, 1'b1);
        for (int k = 0; k < 6; k++) step(16'h0000, 1'b1);
        tbAddr[src_idx(2'd0, KIND_THI)] = 16'h0303;
        tbAddr[src_idx(2'd3, KIND_THI)] = 16'h0F0F;
        bit3  = 16'h0008;
        bit15 = 16'h8000;
        step(bit3 | bit15, 1'b1);
        step(16'h0000, 1'b1);
`ifdef BG_VRAM_FIXED_PRIO_EN
        chk("t3_first", 32'(bus.mem_addr), 32'h0303);
`else
        chk("t3_first", 32'(bus.mem_addr), 32'h0F0F);
`endif
        step(16'h0000, 1'b1);
`ifdef BG_VRAM_FIXED_PRIO_EN
        chk("t3_second", 32'(bus.mem_addr), 32'h0F0F);
`else
        chk("t3_second", 32'(bus.mem_addr), 32'h0303);
`endif
        for (int k = 0; k < 8; k++) step(16'h0000, 1'b1);

        // 4: VRAM stalls five cycles then resumes
        doReset();
        tbAddr[2] = 16'hBEEF;
        step(16'h0004, 1'b0);
        for (int k = 0; k < 5; k++) step(16'h0000, 1'b0);
        for (int k = 0; k < 7; k++) step(16'h0000, 1'b1);

        // 5: repeated requests while busy are ignored
        doReset();
        tbAddr[7] = 16'h7001;
        step(16'h0080, 1'b1);
        step(16'h0000, 1'b1);
        tbAddr[7] = 16'h7002;
        step(16'h0080, 1'b1);
        tbAddr[7] = 16'h7003;
        step(16'h0080, 1'b1);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step(16'h0000, 1'b1);
            if (bus.rsp_valid[7]) cnt++;
        end
        chk("t5_rsp_count", 32'(cnt), 32'd1);

        // 6: reset with three reads in flight drops them
        doReset();
        for (int s = 0; s < 3; s++) tbAddr[s] = 16'(16'hA000 + s);
        step(16'h0007, 1'b1);
        for (int k = 0; k < 3; k++) step(16'h0000, 1'b1);
        doReset();
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step(16'h0000, 1'b0);
            if (bus.rsp_valid != 0) cnt++;
        end
        chk("t6_no_rsp", 32'(cnt), 32'd0);

        // random traffic
        doReset();
        for (int k = 0; k < 400; k++) begin
            for (int s = 0; s < 16; s++) tbAddr[s] = 16'($urandom);
            step(16'($urandom & $urandom), ($urandom % 4) != 0);
        end
        for (int k = 0; k < 30; k++) step(16'h0000, 1'b1);

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule
